// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between the application data path and the multiplexed
// 7-segment scanner: digit data/controls in, anode/cathode drive out.
interface seg7_scan_ctrl_if #(
    parameter int N_DIGITS = 8,
    parameter int PWM_BITS = 4
);
    logic [4*N_DIGITS-1:0] display_bcd;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   digit_en;
    logic [PWM_BITS-1:0]   brightness;
    logic                  blank_lz;
    logic [N_DIGITS-1:0]   anodes;
    logic [6:0]            cathodes;
    logic                  dp_n;
    logic                  frame_tick;

    modport master (
        output display_bcd, dp, digit_en, brightness, blank_lz,
        input  anodes, cathodes, dp_n, frame_tick
    );

    modport slave (
        input  display_bcd, dp, digit_en, brightness, blank_lz,
        output anodes, cathodes, dp_n, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous capture,
// PWM brightness and digit masking. Leading-zero blanking: SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int N_DIGITS = 8,
    parameter int PRESCALE = 100000,
    parameter int PWM_BITS = 4
) (
    input  logic           clk,
    input  logic           reset,
    seg7_scan_ctrl_if.slave disp
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    logic [CNT_W-1:0]      cnt_p0;
    logic [IDX_W-1:0]      idx_p0;
    logic [PWM_BITS-1:0]   pwm_p0;
    logic [4*N_DIGITS-1:0] bcd_p0;
    logic [N_DIGITS-1:0]   dp_p0;
    logic [N_DIGITS-1:0]   en_p0;
    logic                  slot_end_p0;
    logic                  wrap_p0;

    assign slot_end_p0 = (cnt_p0 == CNT_LAST);
    assign wrap_p0     = slot_end_p0 && (idx_p0 == IDX_LAST);

    // Stage p0: scan timing and the shadow copy of the frame being shown
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
            pwm_p0 <= '0;
            bcd_p0 <= '0;
            dp_p0  <= '0;
            en_p0  <= '0;
        end else begin
            pwm_p0 <= pwm_p0 + 1'b1;
            cnt_p0 <= slot_end_p0 ? '0 : cnt_p0 + 1'b1;
            if (slot_end_p0)
                idx_p0 <= wrap_p0 ? '0 : idx_p0 + 1'b1;
            if (wrap_p0) begin
                bcd_p0 <= disp.display_bcd;
                dp_p0  <= disp.dp;
                en_p0  <= disp.digit_en;
            end
        end
    end

    logic [3:0] nib_p0;
    logic       blank_p0;

    assign nib_p0 = bcd_p0[4*int'(idx_p0) +: 4];

`ifdef SEG7_LZ_BLANK_EN
    // A digit blanks only when it and every more-significant nibble are zero
    always_comb begin
        blank_p0 = 1'b0;
        if (disp.blank_lz && (idx_p0 != '0)) begin
            blank_p0 = 1'b1;
            for (int i = 0; i < N_DIGITS; i++) begin
                if ((i >= int'(idx_p0)) && (bcd_p0[4*i +: 4] != 4'h0))
                    blank_p0 = 1'b0;
            end
        end
    end
`else
    logic unused_blank_lz;
    assign unused_blank_lz = disp.blank_lz;
    assign blank_p0 = 1'b0;
`endif

    logic [N_DIGITS-1:0] anodes_d;
    logic [6:0]          cathodes_d;
    logic                dp_n_d;

    always_comb begin
        anodes_d = '1;
        if (en_p0[idx_p0] && (pwm_p0 <= disp.brightness))
            anodes_d[idx_p0] = 1'b0;
        cathodes_d = blank_p0 ? 7'h7F : hex_to_seg(nib_p0);
        dp_n_d     = ~dp_p0[idx_p0];
    end

    logic [N_DIGITS-1:0] anodes_p1;
    logic [6:0]          cathodes_p1;
    logic                dp_n_p1;
    logic                frame_tick_p1;

    // Stage p1: registered pin drive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anodes_p1     <= '1;
            cathodes_p1   <= 7'h7F;
            dp_n_p1       <= 1'b1;
            frame_tick_p1 <= 1'b0;
        end else begin
            anodes_p1     <= anodes_d;
            cathodes_p1   <= cathodes_d;
            dp_n_p1       <= dp_n_d;
            frame_tick_p1 <= wrap_p0;
        end
    end

    assign disp.anodes     = anodes_p1;
    assign disp.cathodes   = cathodes_p1;
    assign disp.dp_n       = dp_n_p1;
    assign disp.frame_tick = frame_tick_p1;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (N_DIGITS=4, PRESCALE=4, PWM_BITS=2).
module tb_seg7_scan_ctrl;
    localparam int N = 4;
    localparam int P = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.N_DIGITS(N), .PWM_BITS(W)) ifc ();

    seg7_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .PWM_BITS(W)) dut (
        .clk  (clk),
        .reset(reset),
        .disp (ifc.slave)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] ca;
        logic       dpn;
        logic       ft;
    } exp_t;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int        m_cnt, m_idx;
    logic [1:0] m_pwm;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp, m_en;

    function automatic exp_t observed();
        observed = {ifc.anodes, ifc.cathodes, ifc.dp_n, ifc.frame_tick};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_pwm = 2'd0;
        m_bcd = '0; m_dp = '0; m_en = '0;
        q.delete();
    endtask

    // Predict the next registered outputs, advance the model, then clock.
    task automatic step();
        exp_t e;
        logic [3:0] nib;
        e.an = 4'hF;
        if (m_en[m_idx] && (m_pwm <= ifc.brightness)) e.an[m_idx] = 1'b0;
        nib  = m_bcd[4*m_idx +: 4];
        e.ca = seg_tab[nib];
`ifdef SEG7_LZ_BLANK_EN
        if (ifc.blank_lz && m_idx != 0 && ((m_bcd >> (4*m_idx)) == 16'h0)) e.ca = 7'h7F;
`endif
        e.dpn = ~m_dp[m_idx];
        e.ft  = (m_cnt == P-1) && (m_idx == N-1);
        q.push_back(e);
        if (m_cnt == P-1) begin
            m_cnt = 0;
            if (m_idx == N-1) begin
                m_idx = 0;
                m_bcd = ifc.display_bcd; m_dp = ifc.dp; m_en = ifc.digit_en;
            end else m_idx++;
        end else m_cnt++;
        m_pwm = m_pwm + 2'd1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        e = '{an: 4'hF, ca: 7'h7F, dpn: 1'b1, ft: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        g = observed(); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL reset_hold: got %h want %h", g, e); end
        reset = 1'b1; model_reset();
        for (int i = 0; i < 22; i++) begin
            step(); e = q.pop_front(); g = observed(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL reset_run[%0d]: got %h want %h", i, g, e); end
        end
        #2 reset = 1'b0;
        #1 g = observed(); e = '{an: 4'hF, ca: 7'h7F, dpn: 1'b1, ft: 1'b0}; n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL reset_async: got %h want %h", g, e); end
        @(posedge clk); #1;
        reset = 1'b1; model_reset();
    endtask

    task automatic test_scan();
        exp_t e, g;
        int ticks = 0;
        for (int i = 0; i < 48; i++) begin
            step(); e = q.pop_front(); g = observed(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL scan[%0d]: got %h want %h", i, g, e); end
            if (g.ft) ticks++;
        end
        n_cmp++;
        if (ticks !== 3) begin n_bad++; $display("FAIL scan_ticks: got %0d want 3", ticks); end
    endtask

    task automatic test_tear_free();
        exp_t e, g;
        logic seen_d = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 6) ifc.display_bcd = 16'hABCD;
            step(); e = q.pop_front(); g = observed(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL tear[%0d]: got %h want %h", i, g, e); end
            if (g.ca == 7'h21) seen_d = 1'b1;
        end
        n_cmp++;
        if (seen_d !== 1'b1) begin n_bad++; $display("FAIL tear_new_frame: got %b want 1", seen_d); end
    endtask

    task automatic test_pwm();
        exp_t e, g;
        for (int b = 1; b >= 0; b--) begin
            ifc.brightness = 2'(b);
            for (int i = 0; i < 20; i++) begin
                step(); e = q.pop_front(); g = observed(); n_cmp++;
                if (g !== e) begin n_bad++; $display("FAIL pwm_b%0d[%0d]: got %h want %h", b, i, g, e); end
            end
        end
        ifc.brightness = 2'd3;
    endtask

    task automatic test_mask();
        exp_t e, g;
        ifc.digit_en = 4'b0101;
        for (int i = 0; i < 36; i++) begin
            step(); e = q.pop_front(); g = observed(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL mask[%0d]: got %h want %h", i, g, e); end
        end
        ifc.digit_en = 4'b0000;
        for (int i = 0; i < 36; i++) begin
            step(); e = q.pop_front(); g = observed(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL mask_off[%0d]: got %h want %h", i, g, e); end
        end
        ifc.digit_en = 4'hF;
    endtask

    task automatic test_blank();
        exp_t e, g;
        ifc.display_bcd = 16'h0050;
        ifc.blank_lz    = 1'b1;
        ifc.dp          = 4'b1001;
        for (int i = 0; i < 36; i++) begin
            step(); e = q.pop_front(); g = observed(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL blank[%0d]: got %h want %h", i, g, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.display_bcd = 16'h1234;
        ifc.dp          = 4'b0010;
        ifc.digit_en    = 4'hF;
        ifc.brightness  = 2'd3;
        ifc.blank_lz    = 1'b0;
        model_reset();
        test_reset();
        test_scan();
        test_tear_free();
        test_pwm();
        test_mask();
        test_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
